fb_mem_arbiter: RTL and testbench

Arbiter that shares one single-port frame-buffer RAM between the RSA ASIP processor's load/store port and the VGA pixel fetch path. The VGA path has priority because it is real-time. The processor is served in the remaining cycles, with a compile-time starvation guard. The block also latches which of two image banks (encrypted or decrypted) the VGA scans out, switching only at frame boundaries so the display never tears. It sits between the processor data-memory decoder, the VGA controller and the frame-buffer RAM.

---
 rtl/fb_mem_arbiter.sv | 106 ++++++++++
 tb/tb_fb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Shares one single-port frame-buffer RAM between VGA fetch (priority) and CPU load/store; grants are combinational, read data returns 1 cycle after grant.
// No backpressure on read returns. Optional CPU starvation guard: FB_ARB_STARVE_GUARD_EN.
module fb_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_bank,
    input  logic              frame_start,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              disp_bank
);

    localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

    logic              w_vga_win;
    logic              w_cpu_win;
    logic              w_starved;
    logic              r_disp_bank;
    logic              r_tag_vga;
    logic              r_tag_cpu;
    logic [ADDR_W:0]   r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

`ifdef FB_ARB_STARVE_GUARD_EN
    logic [3:0] r_wait;

    assign w_starved = cpu_req && (r_wait == LP_STARVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= 4'd0;
        end else if (!cpu_req || w_cpu_win) begin
            r_wait <= 4'd0;
        end else if (r_wait != 4'hF) begin
            r_wait <= r_wait + 4'd1;
        end
    end
`else
    // Strict VGA priority: the CPU can never override, whatever STARVE_MAX is.
    assign w_starved = (LP_STARVE == 4'd0) && 1'b0;
`endif

    always_comb begin
        w_vga_win = 1'b0;
        w_cpu_win = 1'b0;
        if (rst) begin
            if (vga_req && !w_starved) begin
                w_vga_win = 1'b1;
            end else if (cpu_req) begin
                w_cpu_win = 1'b1;
            end
        end
    end

    assign vga_gnt   = w_vga_win;
    assign cpu_gnt   = w_cpu_win;
    assign mem_we    = w_cpu_win && cpu_we;
    assign mem_addr  = w_vga_win ? {r_disp_bank, vga_addr} :
                       w_cpu_win ? cpu_addr : r_mem_addr;
    assign mem_wdata = w_cpu_win ? cpu_wdata : r_mem_wdata;

    // RAM has one cycle of read latency, so the tag lines up with mem_rdata.
    assign vga_rvalid = r_tag_vga;
    assign cpu_rvalid = r_tag_cpu;
    assign vga_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;
    assign disp_bank  = r_disp_bank;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tag_vga   <= 1'b0;
            r_tag_cpu   <= 1'b0;
            r_disp_bank <= 1'b0;
        end else begin
            r_mem_addr  <= mem_addr;
            r_mem_wdata <= mem_wdata;
            r_tag_vga   <= w_vga_win;
            r_tag_cpu   <= w_cpu_win && !cpu_we;
            // Bank only moves at a frame boundary so the picture never tears.
            if (frame_start) begin
                r_disp_bank <= sel_bank;
            end
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a small registered-read RAM model.
module tb_fb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        sel_bank;
    logic        frame_start;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [7:0]  vga_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        disp_bank;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [0:131071];

    fb_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .sel_bank(sel_bank), .frame_start(frame_start),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .disp_bank(disp_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
        ram[17'h00010] = 8'h3C;
        ram[17'h00005] = 8'h77;
        ram[17'h10030] = 8'hB2;

        rst = 1'b0; sel_bank = 1'b1; frame_start = 1'b1;
        vga_req = 1'b0; vga_addr = 16'h0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 17'h0; cpu_wdata = 8'h0;

        // Reset, with a frame_start pulse that must be ignored.
        @(negedge clk);
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        next_cycle();
        @(negedge clk);
        chk("rst_disp_bank", disp_bank, 0);
        next_cycle();
        rst = 1'b1; frame_start = 1'b0; sel_bank = 1'b0;
        @(negedge clk);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_disp_bank", disp_bank, 0);
        chk("idle_mem_addr", mem_addr, 0);

        // VGA only.
        next_cycle();
        vga_req = 1'b1; vga_addr = 16'h0010;
        @(negedge clk);
        chk("vga_gnt", vga_gnt, 1);
        chk("vga_cpu_gnt", cpu_gnt, 0);
        chk("vga_mem_addr", mem_addr, 17'h00010);
        chk("vga_mem_we", mem_we, 0);
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        chk("vga_rvalid", vga_rvalid, 1);
        chk("vga_rdata", vga_rdata, 8'h3C);
        chk("vga_no_cpu_rvalid", cpu_rvalid, 0);
        chk("idle_hold_addr", mem_addr, 17'h00010);
        next_cycle();
        @(negedge clk);
        chk("vga_rvalid_one", vga_rvalid, 0);

        // CPU write then read of bank 1.
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h10020; cpu_wdata = 8'hA5;
        @(negedge clk);
        chk("wr_cpu_gnt", cpu_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 17'h10020);
        chk("wr_mem_wdata", mem_wdata, 8'hA5);
        next_cycle();
        cpu_we = 1'b0; cpu_wdata = 8'h00;
        @(negedge clk);
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("wr_no_rvalid", cpu_rvalid, 0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 8'hA5);
        chk("rd_no_vga_rvalid", vga_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("rd_rvalid_one", cpu_rvalid, 0);

        // Contention: both requests held for 8 cycles.
        next_cycle();
        vga_req = 1'b1; vga_addr = 16'h0020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00005;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef FB_ARB_STARVE_GUARD_EN
            chk($sformatf("cont_vga_gnt_%0d", i), vga_gnt, (i == 4) ? 0 : 1);
            chk($sformatf("cont_cpu_gnt_%0d", i), cpu_gnt, (i == 4) ? 1 : 0);
            chk($sformatf("cont_cpu_rvalid_%0d", i), cpu_rvalid, (i == 5) ? 1 : 0);
            if (i == 5) chk("cont_cpu_rdata", cpu_rdata, 8'h77);
`else
            chk($sformatf("cont_vga_gnt_%0d", i), vga_gnt, 1);
            chk($sformatf("cont_cpu_gnt_%0d", i), cpu_gnt, 0);
            chk($sformatf("cont_cpu_rvalid_%0d", i), cpu_rvalid, 0);
`endif
            next_cycle();
        end
        vga_req = 1'b0; cpu_req = 1'b0;
        next_cycle();

        // Bank switch only at frame_start.
        sel_bank = 1'b1; vga_req = 1'b1; vga_addr = 16'h0030;
        @(negedge clk);
        chk("bank_mid_frame", disp_bank, 0);
        chk("bank_mid_addr", mem_addr, 17'h00030);
        next_cycle();
        frame_start = 1'b1;
        @(negedge clk);
        chk("bank_fs_cycle_addr", mem_addr, 17'h00030);
        next_cycle();
        frame_start = 1'b0;
        @(negedge clk);
        chk("bank_after_fs", disp_bank, 1);
        chk("bank_after_addr", mem_addr, 17'h10030);
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        chk("bank1_rdata", vga_rdata, 8'hB2);
        // sel_bank changes in the very cycle of frame_start: new value wins.
        frame_start = 1'b1; sel_bank = 1'b0;
        next_cycle();
        frame_start = 1'b0;
        @(negedge clk);
        chk("bank_back_0", disp_bank, 0);

        // Reset in the cycle after a VGA grant drops the read.
        next_cycle();
        vga_req = 1'b1; vga_addr = 16'h0010;
        @(negedge clk);
        chk("rr_gnt", vga_gnt, 1);
        next_cycle();
        vga_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rr_rvalid_in_rst", vga_rvalid, 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rr_rvalid_after", vga_rvalid, 0);
        next_cycle();
        vga_req = 1'b1;
        @(negedge clk);
        chk("rr_fresh_gnt", vga_gnt, 1);
        chk("rr_fresh_addr", mem_addr, 17'h00010);
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        chk("rr_fresh_rvalid", vga_rvalid, 1);
        chk("rr_fresh_rdata", vga_rdata, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Write enable must never appear while reset is held.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            total++;
            bad++;
            $error("FAIL rst_mem_we_seen observed=1 expected=0");
        end
    end

endmodule
